// File: rtl/bpf_loader_pkg.sv
// rtl/bpf_loader_pkg.sv - shared constants and FSM encoding for the code memory loader
package bpf_loader_pkg;
  localparam int WORD_W    = 32;
  localparam int WORDS_MIN = 1;
  localparam int WORDS_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_e;
endpackage

// File: rtl/code_mem_loader_if.sv
// rtl/code_mem_loader_if.sv - code memory write port between loader and memory
interface code_mem_loader_if #(
  parameter int CODE_ADDR_WIDTH = 9,
  parameter int WORDS           = 2
);
  localparam int CODE_DATA_WIDTH = bpf_loader_pkg::WORD_W * WORDS;

  logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr;
  logic [CODE_DATA_WIDTH-1:0] code_mem_wr_data;
  logic                       code_mem_wr_en;

  modport master (output code_mem_wr_addr, output code_mem_wr_data, output code_mem_wr_en);
  modport slave  (input  code_mem_wr_addr, input  code_mem_wr_data, input  code_mem_wr_en);
endinterface

// File: rtl/strb_collector.sv
// rtl/strb_collector.sv - word holding registers, valid mask and completion detect
// Optional duplicate-strobe flag under CODE_MEM_LOADER_DUP_ERR_EN.
module strb_collector
  import bpf_loader_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WORD_W*WORDS-1:0]  word_value,
  input  logic [WORDS-1:0]         word_strobe,
  output logic [WORD_W*WORDS-1:0]  hold,
  output logic                     complete,
  output logic                     dup_err
);
  logic [WORDS-1:0] mask;
  logic [WORDS-1:0] strobe_en;

  assign strobe_en = enable ? word_strobe : '0;
  assign complete  = enable && ((mask | word_strobe) == {WORDS{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (strobe_en[k]) hold[k*WORD_W +: WORD_W] <= word_value[k*WORD_W +: WORD_W];
      end
    end
  end

  // The completing cycle clears the mask so the next cycle starts a fresh instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (!enable || complete) begin
      mask <= '0;
    end else begin
      mask <= mask | word_strobe;
    end
  end

`ifdef CODE_MEM_LOADER_DUP_ERR_EN
  logic overwrite;
  assign overwrite = enable && (|(word_strobe & mask)) && !complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_err <= 1'b0;
    end else if (!enable) begin
      dup_err <= 1'b0;
    end else if (overwrite) begin
      dup_err <= 1'b1;
    end
  end
`else
  assign dup_err = 1'b0;
`endif
endmodule

// File: rtl/code_mem_loader.sv
// rtl/code_mem_loader.sv - assembles strobed 32-bit words into instructions and writes code memory
// Optional duplicate-strobe flag under CODE_MEM_LOADER_DUP_ERR_EN.
module code_mem_loader
  import bpf_loader_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = 9,
  parameter int WORDS           = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W*WORDS-1:0]   word_value,
  input  logic [WORDS-1:0]          word_strobe,
  input  logic                      control_start,
  code_mem_loader_if.master         mem,
  output logic [CODE_ADDR_WIDTH:0]  inst_count,
  output logic                      mem_full,
  output logic                      dup_err
);
  localparam int                       DEPTH      = 2 ** CODE_ADDR_WIDTH;
  localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_MAX   = '1;
  localparam logic [CODE_ADDR_WIDTH:0]   LAST_COUNT = (CODE_ADDR_WIDTH+1)'(DEPTH - 1);

  if ((WORDS < WORDS_MIN) || (WORDS > WORDS_MAX)) begin : g_bad_words
    $error("code_mem_loader: WORDS out of range");
  end

  load_state_e                 state, state_next;
  logic                        collect_en;
  logic                        complete;
  logic                        write_go;
  logic                        wr_en_q;
  logic [CODE_ADDR_WIDTH-1:0]  addr_q;
  logic [CODE_ADDR_WIDTH:0]    pending;
  logic [WORD_W*WORDS-1:0]     hold;

  assign collect_en = (state != ST_IDLE) && !control_start;
  // Count including a write still in flight, so the last-address decision is made on completion.
  assign pending    = inst_count + (CODE_ADDR_WIDTH+1)'(wr_en_q);

  strb_collector #(.WORDS(WORDS)) u_collect (
    .clk         (clk),
    .rst         (rst),
    .enable      (collect_en),
    .word_value  (word_value),
    .word_strobe (word_strobe),
    .hold        (hold),
    .complete    (complete),
    .dup_err     (dup_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    write_go   = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_LOAD;
      ST_LOAD: begin
        if (complete) begin
          write_go = 1'b1;
          if (pending == LAST_COUNT) state_next = ST_FULL;
        end
      end
      ST_FULL: state_next = ST_FULL;
      default: state_next = ST_IDLE;
    endcase
    if (control_start) begin
      state_next = ST_IDLE;
      write_go   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      inst_count <= '0;
    end else begin
      wr_en_q <= write_go;
      if (state == ST_IDLE || control_start) begin
        addr_q     <= '0;
        inst_count <= '0;
      end else if (wr_en_q) begin
        inst_count <= inst_count + 1'b1;
        if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign mem.code_mem_wr_addr = addr_q;
  assign mem.code_mem_wr_data = hold;
  assign mem.code_mem_wr_en   = wr_en_q;
  assign mem_full             = (state == ST_FULL);
endmodule
